link_slave_fifo: RTL and testbench

LINK_SLAVE_FIFO -- requirements
Module: link_slave_fifo

---
 rtl/link_pkg.sv | 14 +
 rtl/link_fifo.sv | 57 +++++
 rtl/link_slave_fifo.sv | 92 +++++++++
 tb/tb_link_slave_fifo.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared FSM encoding and default parameters for the 4-phase link slave.
package link_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } link_state_t;

  localparam int LINK_DATA_W   = 8;
  localparam int LINK_HOLD_CYC = 2;
  localparam int LINK_DEPTH    = 4;

endpackage

// File: rtl/link_fifo.sv
// Show-ahead receive buffer: power-of-2 storage, wrapping pointers and occupancy count.
module link_fifo
  import link_pkg::*;
#(
  parameter int DATA_W = LINK_DATA_W,
  parameter int DEPTH  = LINK_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_wr;
  logic              do_rd;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/link_slave_fifo.sv
// 4-phase handshake slave: captures each request once, holds ack for HOLD_CYC
// cycles, and queues the captured words for a downstream consumer.
module link_slave_fifo
  import link_pkg::*;
#(
  parameter int DATA_W   = LINK_DATA_W,
  parameter int HOLD_CYC = LINK_HOLD_CYC,
  parameter int DEPTH    = LINK_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic [DATA_W-1:0]      data_in,
  output logic                   ack,
  output logic [DATA_W-1:0]      last_word,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   proto_err
);

  localparam int HC_W = $clog2(HOLD_CYC + 1);
  localparam logic [HC_W-1:0] HOLD_LD  = HC_W'(HOLD_CYC);
  localparam logic [HC_W-1:0] HOLD_ONE = HC_W'(1);

  link_state_t       state_q;
  logic              ack_q;
  logic [DATA_W-1:0] last_word_q;
  logic [HC_W-1:0]   hold_q;
  logic              proto_err_q;
  logic              capture;

  // Full comes from registered count, so a same-cycle pop cannot admit a write.
  assign capture = (state_q == IDLE) && req && !full;

  assign ack       = ack_q;
  assign last_word = last_word_q;
  assign proto_err = proto_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_REL;
      ack_q       <= 1'b0;
      last_word_q <= '0;
      hold_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture) begin
            last_word_q <= data_in;
            ack_q       <= 1'b1;
            hold_q      <= HOLD_LD;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (!req) proto_err_q <= 1'b1;
          if (hold_q > HOLD_ONE) begin
            hold_q <= hold_q - HOLD_ONE;
          end else begin
            hold_q  <= '0;
            ack_q   <= 1'b0;
            state_q <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!req) state_q <= IDLE;
        end
        default: state_q <= WAIT_REL;
      endcase
    end
  end

  link_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (capture),
    .wr_data_i (data_in),
    .rd_en_i   (rd_en),
    .rd_data_o (rd_data),
    .empty_o   (empty),
    .full_o    (full),
    .count_o   (count)
  );

endmodule

// File: tb/tb_link_slave_fifo.sv
// Directed bench for link_slave_fifo: a queue-based transfer model checked every
// cycle, plus literal expectations at the key handshake points.
module tb_link_slave_fifo;

  localparam int DATA_W   = 8;
  localparam int HOLD_CYC = 2;
  localparam int DEPTH    = 4;

  logic              clk;
  logic              rst_n;
  logic              req;
  logic [DATA_W-1:0] data_in;
  logic              ack;
  logic [DATA_W-1:0] last_word;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [2:0]        count;
  logic              proto_err;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] mq [$];
  logic [DATA_W-1:0] mLast;
  logic              mProto;
  int                mAckLeft;
  logic              mNeedRel;
  logic              modelValid = 1'b0;

  link_slave_fifo #(
    .DATA_W   (DATA_W),
    .HOLD_CYC (HOLD_CYC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .ack       (ack),
    .last_word (last_word),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] d, input logic rd, input logic rs);
    req     = r;
    data_in = d;
    rd_en   = rd;
    rst_n   = rs;
    @(posedge clk);
    #1;
  endtask

  // One complete 4-phase transfer, optionally popping on the capture edge.
  task automatic doTransfer(input logic [7:0] d, input logic popAtCapture);
    applyStimulus(1'b1, d, popAtCapture, 1'b1);
    applyStimulus(1'b1, d, 1'b0, 1'b1);
    applyStimulus(1'b1, d, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  // Transfer model: ack is high for HOLD_CYC edges after a capture, then req
  // must be seen low once before the next capture can happen.
  initial begin
    logic rq, rd, rs, fullBefore, emptyBefore, doCap;
    logic [DATA_W-1:0] d;
    forever begin
      @(posedge clk);
      rq = req; rd = rd_en; rs = rst_n; d = data_in;
      if (!rs) begin
        mq.delete();
        mLast = '0; mProto = 1'b0; mAckLeft = 0; mNeedRel = 1'b1;
        modelValid = 1'b1;
      end else begin
        fullBefore  = (mq.size() == DEPTH);
        emptyBefore = (mq.size() == 0);
        doCap = 1'b0;
        if (mAckLeft > 0) begin
          if (!rq) mProto = 1'b1;
          mAckLeft--;
          if (mAckLeft == 0) mNeedRel = 1'b1;
        end else if (mNeedRel) begin
          if (!rq) mNeedRel = 1'b0;
        end else if (rq && !fullBefore) begin
          doCap = 1'b1;
        end
        if (rd && !emptyBefore) void'(mq.pop_front());
        if (doCap) begin
          mq.push_back(d);
          mLast = d;
          mAckLeft = HOLD_CYC;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (modelValid) begin
        checkOutput("ack",       32'(ack),       32'(mAckLeft > 0));
        checkOutput("last_word", 32'(last_word), 32'(mLast));
        checkOutput("count",     32'(count),     32'(mq.size()));
        checkOutput("empty",     32'(empty),     32'(mq.size() == 0));
        checkOutput("full",      32'(full),      32'(mq.size() == DEPTH));
        checkOutput("proto_err", 32'(proto_err), 32'(mProto));
        if (mq.size() > 0) checkOutput("rd_data", 32'(rd_data), 32'(mq[0]));
      end
    end
  end

  initial begin
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rst_ack",   32'(ack),       32'h0);
    checkOutput("rst_count", 32'(count),     32'h0);
    checkOutput("rst_empty", 32'(empty),     32'h1);
    checkOutput("rst_full",  32'(full),      32'h0);
    checkOutput("rst_last",  32'(last_word), 32'h0);
    checkOutput("rst_perr",  32'(proto_err), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Single transfer
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b1);
    checkOutput("single_ack1",  32'(ack),       32'h1);
    checkOutput("single_last",  32'(last_word), 32'hA5);
    checkOutput("single_count", 32'(count),     32'h1);
    checkOutput("single_rd",    32'(rd_data),   32'hA5);
    checkOutput("model_single", 32'(mq.size()), 32'h1);
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b1);
    checkOutput("single_ack2", 32'(ack), 32'h1);
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b1);
    checkOutput("single_ack3", 32'(ack), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("single_perr", 32'(proto_err), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("single_pop_empty", 32'(empty), 32'h1);

    // Backpressure
    doTransfer(8'h11, 1'b0);
    doTransfer(8'h12, 1'b0);
    doTransfer(8'h13, 1'b0);
    doTransfer(8'h14, 1'b0);
    checkOutput("bp_full", 32'(full), 32'h1);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
    checkOutput("bp_held_ack",   32'(ack),   32'h0);
    checkOutput("bp_held_count", 32'(count), 32'h4);
    checkOutput("bp_held_last",  32'(last_word), 32'h14);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b1);
    checkOutput("bp_pop_ack",   32'(ack),   32'h0);
    checkOutput("bp_pop_count", 32'(count), 32'h3);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
    checkOutput("bp_cap_ack",   32'(ack),       32'h1);
    checkOutput("bp_cap_count", 32'(count),     32'h4);
    checkOutput("bp_cap_last",  32'(last_word), 32'h55);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("bp_head", 32'(rd_data), 32'h12);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("bp_drained", 32'(count), 32'h0);

    // Held req: one capture only
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
    checkOutput("held_count", 32'(count),     32'h1);
    checkOutput("held_ack",   32'(ack),       32'h0);
    checkOutput("held_last",  32'(last_word), 32'h77);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h78, 1'b0, 1'b1);
    checkOutput("held_next_count", 32'(count), 32'h2);
    checkOutput("held_next_ack",   32'(ack),   32'h1);
    applyStimulus(1'b1, 8'h78, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h78, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);

    // Protocol error: req drops during first hold cycle
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b1);
    checkOutput("perr_before", 32'(proto_err), 32'h0);
    applyStimulus(1'b0, 8'h33, 1'b0, 1'b1);
    checkOutput("perr_set", 32'(proto_err), 32'h1);
    checkOutput("perr_ack", 32'(ack),       32'h1);
    checkOutput("model_perr", 32'(mProto),  32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("perr_ack_drop", 32'(ack), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    doTransfer(8'h44, 1'b0);
    checkOutput("perr_sticky", 32'(proto_err), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("perr_cleared", 32'(proto_err), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Wrap with simultaneous capture and pop
    doTransfer(8'h01, 1'b0);
    checkOutput("wrap_c1", 32'(count), 32'h1);
    doTransfer(8'h02, 1'b1);
    checkOutput("wrap_c2",  32'(count),   32'h1);
    checkOutput("wrap_h2",  32'(rd_data), 32'h02);
    doTransfer(8'h03, 1'b0);
    doTransfer(8'h04, 1'b0);
    checkOutput("wrap_c4", 32'(count), 32'h3);
    doTransfer(8'h05, 1'b1);
    doTransfer(8'h06, 1'b1);
    doTransfer(8'h07, 1'b1);
    checkOutput("wrap_c7", 32'(count),   32'h3);
    checkOutput("wrap_h7", 32'(rd_data), 32'h05);
    checkOutput("model_wrap_head", 32'(mq[0]), 32'h05);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("wrap_h6", 32'(rd_data), 32'h06);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("wrap_hlast", 32'(rd_data), 32'h07);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("empty_pop_count", 32'(count), 32'h0);
    checkOutput("empty_pop_flag",  32'(empty), 32'h1);

    // Reset in the middle of a hold
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1);
    checkOutput("mid_ack", 32'(ack), 32'h1);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    checkOutput("mid_rst_ack",   32'(ack),       32'h0);
    checkOutput("mid_rst_empty", 32'(empty),     32'h1);
    checkOutput("mid_rst_last",  32'(last_word), 32'h0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1);
    checkOutput("mid_norecap1", 32'(count), 32'h0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1);
    checkOutput("mid_norecap2", 32'(count), 32'h0);
    checkOutput("mid_norecap_ack", 32'(ack), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h9A, 1'b0, 1'b1);
    checkOutput("mid_recap_count", 32'(count),     32'h1);
    checkOutput("mid_recap_last",  32'(last_word), 32'h9A);
    applyStimulus(1'b1, 8'h9A, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h9A, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
